main_mem_write_arbiter: RTL and testbench

- Shares the single write port of dual_port_main_memory between two requesters.
  - The CPU data path: memory-stage stores and loads.
  - A program-load DMA engine that streams words into memory from a base address.
- CPU reads use read port 1 and are never blocked.
- CPU stores and DMA beats contend for the write port. CPU wins by default; a starvation counter guarantees DMA progress.
- Produces cpu_stall for the stall_detector / pipeline freeze logic.

---
 rtl/main_mem_write_arbiter_pkg.sv | 28 ++
 rtl/main_mem_write_arbiter_dma_burst_counter.sv | 45 ++++
 rtl/main_mem_write_arbiter.sv | 131 +++++++++++++
 tb/tb_main_mem_write_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_write_arbiter_pkg.sv
// Shared types and constants for the main-memory write-port arbiter.
// Optional perf counters are enabled with MEM_ARB_PERF_COUNTERS_EN.
package main_mem_write_arbiter_pkg;

  localparam int unsigned ADDR_W           = 32;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned WAIT_W           = 4;
  localparam int unsigned PERF_W           = 32;
  localparam int unsigned DEF_STARVE_LIMIT = 4;
  localparam int unsigned DEF_LEN_W        = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RUN  = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // Saturating increment for the starvation counter
  function automatic logic [WAIT_W-1:0] wait_sat_inc(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + WAIT_W'(1);
  endfunction

endpackage

// File: rtl/main_mem_write_arbiter_dma_burst_counter.sv
// DMA burst address/remaining-beat tracker; flags the final beat of a burst.
module main_mem_write_arbiter_dma_burst_counter
  import main_mem_write_arbiter_pkg::*;
#(
  parameter int unsigned LEN_W = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_beat_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;

  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    if (load_i) begin
      addr_d   = base_i;
      remain_d = len_i;
    end else if (step_i) begin
      addr_d   = addr_q + ADDR_W'(1);
      remain_d = remain_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  assign addr_o      = addr_q;
  assign last_beat_o = (remain_q == LEN_W'(1));

endmodule

// File: rtl/main_mem_write_arbiter.sv
// Shares the memory write port between CPU stores and a program-load DMA burst.
// Define MEM_ARB_PERF_COUNTERS_EN to add stall/beat performance counters.
module main_mem_write_arbiter
  import main_mem_write_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned LEN_W        = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] dma_base,
  input  logic [LEN_W-1:0]  dma_len,
  input  logic              dma_wvalid,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_wready,
  output logic              dma_busy,
  output logic              dma_done,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen
`ifdef MEM_ARB_PERF_COUNTERS_EN
  ,
  output logic [PERF_W-1:0] perf_cpu_stall_cycles,
  output logic [PERF_W-1:0] perf_dma_beats
`endif
);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              run, conflict, dma_win, beat_acc, burst_load, last_beat;
  logic [ADDR_W-1:0] burst_addr;
  wr_req_t           dma_req, cpu_wr, wr_sel;

  main_mem_write_arbiter_dma_burst_counter #(.LEN_W(LEN_W)) u_burst (
    .clk        (clk),
    .rst        (rst),
    .load_i     (burst_load),
    .base_i     (dma_base),
    .len_i      (dma_len),
    .step_i     (beat_acc),
    .addr_o     (burst_addr),
    .last_beat_o(last_beat)
  );

  // Same-cycle arbitration: CPU wins unless DMA has starved long enough
  assign run        = (state_q == ARB_RUN);
  assign conflict   = cpu_req & cpu_we & dma_wvalid & run;
  assign dma_win    = conflict & (32'(wait_q) >= STARVE_LIMIT);
  assign dma_wready = run & (~conflict | dma_win);
  assign beat_acc   = dma_wvalid & dma_wready;
  assign cpu_gnt    = cpu_req & (~cpu_we | ~dma_win);
  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign mem_wen    = (cpu_gnt & cpu_we) | beat_acc;

  assign dma_req    = '{addr: burst_addr, data: dma_wdata};
  assign cpu_wr     = '{addr: cpu_addr, data: cpu_wdata};
  assign wr_sel     = beat_acc ? dma_req : cpu_wr;
  assign mem_waddr  = wr_sel.addr;
  assign mem_wdata  = wr_sel.data;

  // Loads bypass arbitration entirely; read port is asynchronous
  assign mem_raddr  = cpu_addr;
  assign cpu_rdata  = mem_rdata;

  assign dma_busy   = run;
  assign dma_done   = (state_q == ARB_DONE);

  always_comb begin
    state_d    = state_q;
    burst_load = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (dma_start) begin
          if (dma_len != '0) begin
            state_d    = ARB_RUN;
            burst_load = 1'b1;
          end else begin
            state_d    = ARB_DONE;
          end
        end
      end
      ARB_RUN:  if (beat_acc && last_beat) state_d = ARB_DONE;
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if ((state_q == ARB_IDLE) || beat_acc) wait_d = '0;
    else if (conflict && !dma_win)         wait_d = wait_sat_inc(wait_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

`ifdef MEM_ARB_PERF_COUNTERS_EN
  logic [PERF_W-1:0] stall_cnt_q, beat_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      if (cpu_stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      if (beat_acc && !(&beat_cnt_q))   beat_cnt_q  <= beat_cnt_q + PERF_W'(1);
    end
  end

  assign perf_cpu_stall_cycles = stall_cnt_q;
  assign perf_dma_beats        = beat_cnt_q;
`endif

endmodule

// File: tb/tb_main_mem_write_arbiter.sv
// Self-checking bench: vector table, directed corner sequences and a random run
// against a transaction-level model of the DMA burst and write-port sharing.
module tb_main_mem_write_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_gnt, cpu_stall;
  logic        dma_start, dma_wvalid, dma_wready, dma_busy, dma_done;
  logic [31:0] dma_base, dma_wdata;
  logic [15:0] dma_len;
  logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic        mem_wen;
`ifdef MEM_ARB_PERF_COUNTERS_EN
  logic [31:0] perf_cpu_stall_cycles, perf_dma_beats;
`endif

  main_mem_write_arbiter #(.STARVE_LIMIT(LIMIT), .LEN_W(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dma_start(dma_start), .dma_base(dma_base), .dma_len(dma_len),
    .dma_wvalid(dma_wvalid), .dma_wdata(dma_wdata), .dma_wready(dma_wready),
    .dma_busy(dma_busy), .dma_done(dma_done),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen)
`ifdef MEM_ARB_PERF_COUNTERS_EN
    , .perf_cpu_stall_cycles(perf_cpu_stall_cycles), .perf_dma_beats(perf_dma_beats)
`endif
  );

  always #5 clk = ~clk;

  // Environment memory (indexed by the low address byte) and the model's copy
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  assign mem_rdata = mem[mem_raddr[7:0]];

  int checks = 0;
  int errors = 0;

  // Model of the burst engine: what is left to transfer and how long DMA has starved
  bit          m_active, m_done;
  logic [31:0] m_addr;
  int          m_left, m_lost, m_stalls, m_beats;

  typedef struct {
    logic        start;
    logic [31:0] base;
    logic [15:0] len;
    logic        wvalid;
    logic [31:0] wdata;
    logic        e_wen;
    logic [31:0] e_waddr;
    logic        e_wready;
    logic        e_busy;
    logic        e_done;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_addr = '0;
    m_left = 0; m_lost = 0; m_stalls = 0; m_beats = 0;
  endtask

  task automatic drive(input logic start, input logic [31:0] base, input logic [15:0] len,
                       input logic wv, input logic [31:0] wd, input logic cr,
                       input logic cw, input logic [31:0] ca, input logic [31:0] cd);
    dma_start = start; dma_base = base; dma_len = len; dma_wvalid = wv; dma_wdata = wd;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
  endtask

  // Called at the falling edge: check against the model, then step model and memory
  task automatic advance();
    bit          conflict, win, acc, gnt, wen, was_idle, nd;
    logic [31:0] ea, ed;
    logic        w_en;
    logic [31:0] w_a, w_d;
    was_idle = !m_active && !m_done;
    conflict = cpu_req && cpu_we && dma_wvalid && m_active;
    win      = conflict && (m_lost >= int'(LIMIT));
    acc      = m_active && dma_wvalid && (!conflict || win);
    gnt      = cpu_req && !win;
    wen      = (gnt && cpu_we) || acc;
    ea       = acc ? m_addr : cpu_addr;
    ed       = acc ? dma_wdata : cpu_wdata;
    chk("dma_wready", 32'(dma_wready), 32'(m_active && (!conflict || win)));
    chk("cpu_gnt",    32'(cpu_gnt),    32'(gnt));
    chk("cpu_stall",  32'(cpu_stall),  32'(cpu_req && !gnt));
    chk("mem_wen",    32'(mem_wen),    32'(wen));
    if (wen) begin
      chk("mem_waddr", mem_waddr, ea);
      chk("mem_wdata", mem_wdata, ed);
    end
    chk("dma_busy",   32'(dma_busy),   32'(m_active));
    chk("dma_done",   32'(dma_done),   32'(m_done));
    chk("mem_raddr",  mem_raddr,       cpu_addr);
    chk("cpu_rdata",  cpu_rdata,       ref_mem[cpu_addr[7:0]]);
`ifdef MEM_ARB_PERF_COUNTERS_EN
    chk("perf_stalls", perf_cpu_stall_cycles, 32'(m_stalls));
    chk("perf_beats",  perf_dma_beats,        32'(m_beats));
`endif
    if (cpu_req && !gnt) m_stalls++;
    if (acc) begin
      ref_mem[m_addr[7:0]] = dma_wdata;
      m_beats++;
    end else if (gnt && cpu_we) begin
      ref_mem[cpu_addr[7:0]] = cpu_wdata;
    end
    nd = 0;
    if (acc) begin
      m_addr = m_addr + 32'd1;
      m_left--;
      m_lost = 0;
      if (m_left == 0) begin m_active = 0; nd = 1; end
    end else if (conflict) begin
      m_lost = (m_lost < 15) ? m_lost + 1 : 15;
    end
    if (was_idle) begin
      m_lost = 0;
      if (dma_start) begin
        if (dma_len != 16'd0) begin
          m_active = 1; m_addr = dma_base; m_left = int'(dma_len);
        end else begin
          nd = 1;
        end
      end
    end
    m_done = nd;
    w_en = mem_wen; w_a = mem_waddr; w_d = mem_wdata;
    @(posedge clk);
    if (w_en) mem[w_a[7:0]] = w_d;
    #1;
  endtask

  initial begin
    logic [31:0] beats0;
    beats0 = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hC000_0000 | 32'(i);
      ref_mem[i] = 32'hC000_0000 | 32'(i);
    end
    tbl[0] = '{1'b1, 32'h100, 16'd3, 1'b1, 32'hA0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'h0,   16'd0, 1'b1, 32'hA1, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 32'h0,   16'd0, 1'b1, 32'hA2, 1'b1, 32'h101, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 32'h0,   16'd0, 1'b1, 32'hA3, 1'b1, 32'h102, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 32'h0,   16'd0, 1'b1, 32'hA4, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 32'h200, 16'd0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 32'h300, 16'd5, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 32'h0,   16'd0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0};

    // Reset state with a DMA beat offered
    rst = 1'b0;
    model_reset();
    drive(1'b0, '0, '0, 1'b1, 32'h55, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    chk("rst_busy",   32'(dma_busy),   32'd0);
    chk("rst_done",   32'(dma_done),   32'd0);
    chk("rst_wready", 32'(dma_wready), 32'd0);
    chk("rst_wen",    32'(mem_wen),    32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Vector table: 3-beat burst, zero-length burst, start ignored in DONE
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].start, tbl[i].base, tbl[i].len, tbl[i].wvalid, tbl[i].wdata,
            1'b0, 1'b0, 32'h0, 32'h0);
      #4;
      chk($sformatf("tbl%0d_wen", i),    32'(mem_wen),    32'(tbl[i].e_wen));
      if (tbl[i].e_wen) chk($sformatf("tbl%0d_waddr", i), mem_waddr, tbl[i].e_waddr);
      chk($sformatf("tbl%0d_wready", i), 32'(dma_wready), 32'(tbl[i].e_wready));
      chk($sformatf("tbl%0d_busy", i),   32'(dma_busy),   32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_done", i),   32'(dma_done),   32'(tbl[i].e_done));
      advance();
    end

    // Starvation: CPU stores every cycle, DMA wins every fifth conflict
    drive(1'b1, 32'h40, 16'd2, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    #4; advance();
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 5; k++) begin
        drive(1'b0, '0, '0, 1'b1, 32'hD0 + 32'(b), 1'b1, 1'b1,
              32'h80 + 32'(b * 5 + k), $urandom);
        #4;
        chk($sformatf("starve_stall_b%0d_k%0d", b, k),  32'(cpu_stall),  32'(k == 4));
        chk($sformatf("starve_wready_b%0d_k%0d", b, k), 32'(dma_wready), 32'(k == 4));
        if (k == 4) chk($sformatf("starve_waddr_b%0d", b), mem_waddr, 32'h40 + 32'(b));
        advance();
      end
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    #4;
    chk("starve_done", 32'(dma_done), 32'd1);
    advance();

    // Load racing a DMA write to the same word sees the old contents
    drive(1'b1, 32'h20, 16'd1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    #4; advance();
    drive(1'b0, '0, '0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h20, '0);
    #4;
    chk("raw_gnt",   32'(cpu_gnt),   32'd1);
    chk("raw_stall", 32'(cpu_stall), 32'd0);
    chk("raw_rdata", cpu_rdata,      32'hC000_0020);
    chk("raw_waddr", mem_waddr,      32'h20);
    advance();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 32'h20, '0);
    #4;
    chk("raw_after", cpu_rdata, 32'h1234_5678);
    advance();

    // Address wrap at the top of the address space
`ifdef MEM_ARB_PERF_COUNTERS_EN
    beats0 = perf_dma_beats;
`endif
    drive(1'b1, 32'hFFFF_FFFF, 16'd2, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    #4; advance();
    drive(1'b0, '0, '0, 1'b1, 32'hE0, 1'b0, 1'b0, '0, '0);
    #4; chk("wrap_addr0", mem_waddr, 32'hFFFF_FFFF); advance();
    drive(1'b0, '0, '0, 1'b1, 32'hE1, 1'b0, 1'b0, '0, '0);
    #4; chk("wrap_addr1", mem_waddr, 32'h0000_0000); advance();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    #4;
`ifdef MEM_ARB_PERF_COUNTERS_EN
    chk("wrap_perf_beats", perf_dma_beats - beats0, 32'd2);
`endif
    advance();

    // Reset in the middle of an 8-beat burst (5 beats left)
    drive(1'b1, 32'h300, 16'd8, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    #4; advance();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, '0, 1'b1, 32'hB0 + 32'(k), 1'b0, 1'b0, '0, '0);
      #4; advance();
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_busy",   32'(dma_busy),   32'd0);
    chk("mid_rst_done",   32'(dma_done),   32'd0);
    chk("mid_rst_wen",    32'(mem_wen),    32'd0);
    chk("mid_rst_wready", 32'(dma_wready), 32'd0);
    model_reset();
    #3; advance();
    #4; advance();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 32'h302, '0);
    for (int k = 0; k < 3; k++) begin
      #4; advance();
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) == 0), $urandom, 16'($urandom_range(0, 5)),
            ($urandom_range(0, 9) < 7), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 255)), $urandom);
      #4; advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
